// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: PC-stage request, byte-wide memory read port and the
// assembled instruction handed downstream.
interface instruction_fetch_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0] program_counter;
  logic                     fetch;
  logic                     flush;
  logic                     mem_read;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_ready;
  logic [7:0]               mem_data;
  logic [31:0]              instruction;
  logic                     instruction_valid;
  logic                     instruction_ready;
  logic                     misaligned;
  logic                     busy;

  // The fetch unit drives memory requests and the instruction word.
  modport master (
    input  program_counter, fetch, flush, mem_ready, mem_data, instruction_ready,
    output mem_read, mem_address, instruction, instruction_valid, misaligned, busy
  );

  // The surrounding pipeline and memory.
  modport slave (
    output program_counter, fetch, flush, mem_ready, mem_data, instruction_ready,
    input  mem_read, mem_address, instruction, instruction_valid, misaligned, busy
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetches a 32-bit little-endian instruction as four byte reads, holds it until
// consumed, and locks into a sticky fault on a misaligned program counter.
module instruction_fetch #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]               state;
  logic [1:0]               index;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [31:0]              instruction;
  logic                     start;

  // A new fetch may begin from IDLE, or from DONE in the same cycle the held
  // word is consumed (back-to-back).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    start = 1'b0;
    if (bus.fetch && !bus.flush) begin
      if (state == IDLE)
        start = 1'b1;
      else if (state == DONE && bus.instruction_ready)
        start = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      index       <= 2'd0;
      base        <= '0;
      instruction <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.flush) begin
            state <= IDLE;
            index <= 2'd0;
          end else if (start) begin
            base  <= bus.program_counter;
            index <= 2'd0;
            state <= (bus.program_counter[1:0] == 2'b00) ? READ : FAULT;
          end else if (state == DONE && bus.instruction_ready) begin
            state <= IDLE;
          end
        end
        READ: begin
          if (bus.flush) begin
            state <= IDLE;
            index <= 2'd0;
          end else if (bus.mem_ready) begin
            instruction[{index, 3'b000} +: 8] <= bus.mem_data;
            index <= index + 2'd1;
            if (index == 2'd3)
              state <= DONE;
          end
        end
        default: ; // FAULT is left only through reset
      endcase
    end
  end

  assign bus.mem_read          = (state == READ);
  assign bus.mem_address       = base + ADDRESS_WIDTH'(index);
  assign bus.instruction       = instruction;
  assign bus.instruction_valid = (state == DONE);
  assign bus.misaligned        = (state == FAULT);
  assign bus.busy              = (state != IDLE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, corner-case
// sequences and random traffic against a transaction-level model.
module tb_instruction_fetch;
  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  instruction_fetch_if #(.ADDRESS_WIDTH(32)) bus ();

  instruction_fetch #(.ADDRESS_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: a fetch is "active" while bytes are still owed, a word is
  // "held" once all four arrived, "faulted" is sticky until reset.
  bit          m_active, m_have, m_fault;
  int          m_got;
  logic [31:0] m_base, m_word;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit f, input bit fl, input logic [31:0] pc,
                              input bit mr, input logic [7:0] md, input bit ir);
    if (rst) begin
      m_active = 0; m_have = 0; m_fault = 0; m_got = 0; m_base = 0; m_word = 0;
    end else if (m_fault) begin
    end else if (fl) begin
      m_active = 0; m_have = 0; m_got = 0;
    end else if (m_active) begin
      if (mr) begin
        m_word[8*m_got +: 8] = md;
        m_got++;
        if (m_got == 4) begin
          m_active = 0; m_have = 1; m_got = 0;
        end
      end
    end else if (!m_have || ir) begin
      m_have = 0;
      if (f) begin
        m_base = pc;
        if (pc % 4 != 0) m_fault = 1;
        else begin m_active = 1; m_got = 0; end
      end
    end
  endtask

  task automatic step(input bit rst, input bit f, input bit fl, input logic [31:0] pc,
                      input bit mr, input logic [7:0] md, input bit ir);
    reset                 = rst;
    bus.fetch             = f;
    bus.flush             = fl;
    bus.program_counter   = pc;
    bus.mem_ready         = mr;
    bus.mem_data          = md;
    bus.instruction_ready = ir;
    model_update(rst, f, fl, pc, mr, md, ir);
    @(posedge clock);
    #1;
    check("model mem_read", 32'(bus.mem_read), 32'(m_active));
    if (m_active) check("model mem_address", bus.mem_address, m_base + 32'(m_got));
    check("model instruction_valid", 32'(bus.instruction_valid), 32'(m_have));
    check("model instruction", bus.instruction, m_word);
    check("model misaligned", 32'(bus.misaligned), 32'(m_fault));
    check("model busy", 32'(bus.busy), 32'(m_active || m_have || m_fault));
  endtask

  typedef struct {
    bit          rst, fetch, flush;
    logic [31:0] pc;
    bit          mrdy;
    logic [7:0]  mdata;
    bit          irdy;
    bit          e_read;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_instr;
    bit          e_mis, e_busy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] held;
    reset = 1'b1;
    bus.fetch = 0; bus.flush = 0; bus.program_counter = 0;
    bus.mem_ready = 0; bus.mem_data = 0; bus.instruction_ready = 0;
    model_update(1, 0, 0, 0, 0, 0, 0);

    // rst fetch flush pc mrdy data irdy | read addr valid instr mis busy
    vecs.push_back('{1, 0, 0, 32'h0,  0, 8'h00, 0,  0, 32'h0,  0, 32'h0,        0, 0});
    vecs.push_back('{0, 1, 0, 32'h10, 0, 8'h00, 0,  1, 32'h10, 0, 32'h0,        0, 1});
    vecs.push_back('{0, 0, 0, 32'h0,  1, 8'h13, 0,  1, 32'h11, 0, 32'h13,       0, 1});
    vecs.push_back('{0, 0, 0, 32'h0,  1, 8'h05, 0,  1, 32'h12, 0, 32'h0513,     0, 1});
    vecs.push_back('{0, 0, 0, 32'h0,  1, 8'h10, 0,  1, 32'h13, 0, 32'h10_0513,  0, 1});
    vecs.push_back('{0, 0, 0, 32'h0,  1, 8'h00, 0,  0, 32'h0,  1, 32'h0010_0513, 0, 1});
    vecs.push_back('{0, 0, 0, 32'h0,  0, 8'h00, 0,  0, 32'h0,  1, 32'h0010_0513, 0, 1});
    vecs.push_back('{0, 0, 0, 32'h0,  0, 8'h00, 1,  0, 32'h0,  0, 32'h0010_0513, 0, 0});
    vecs.push_back('{0, 0, 0, 32'h0,  0, 8'h00, 1,  0, 32'h0,  0, 32'h0010_0513, 0, 0});
    vecs.push_back('{0, 1, 1, 32'h40, 1, 8'h00, 0,  0, 32'h0,  0, 32'h0010_0513, 0, 0});
    vecs.push_back('{0, 1, 0, 32'h6,  1, 8'h00, 0,  0, 32'h0,  0, 32'h0010_0513, 1, 1});
    vecs.push_back('{0, 0, 1, 32'h0,  1, 8'h00, 0,  0, 32'h0,  0, 32'h0010_0513, 1, 1});
    vecs.push_back('{0, 1, 0, 32'h10, 1, 8'h00, 1,  0, 32'h0,  0, 32'h0010_0513, 1, 1});
    vecs.push_back('{1, 1, 0, 32'h10, 1, 8'h00, 0,  0, 32'h0,  0, 32'h0,        0, 0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].fetch, vecs[i].flush, vecs[i].pc,
           vecs[i].mrdy, vecs[i].mdata, vecs[i].irdy);
      check($sformatf("vec%0d mem_read", i), 32'(bus.mem_read), 32'(vecs[i].e_read));
      if (vecs[i].e_read) check($sformatf("vec%0d mem_address", i), bus.mem_address, vecs[i].e_addr);
      check($sformatf("vec%0d valid", i), 32'(bus.instruction_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d instruction", i), bus.instruction, vecs[i].e_instr);
      check($sformatf("vec%0d misaligned", i), 32'(bus.misaligned), 32'(vecs[i].e_mis));
      check($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
    end

    // Two wait states on byte 2: address 0x12 visible three cycles, valid at N+7.
    step(0, 1, 0, 32'h10, 0, 8'h00, 0);
    step(0, 0, 0, 32'h0, 1, 8'h13, 0);
    step(0, 0, 0, 32'h0, 1, 8'h05, 0);
    check("wait addr cycle1", bus.mem_address, 32'h12);
    step(0, 0, 0, 32'h0, 0, 8'hee, 0);
    check("wait addr cycle2", bus.mem_address, 32'h12);
    step(0, 0, 0, 32'h0, 0, 8'hee, 0);
    check("wait addr cycle3", bus.mem_address, 32'h12);
    step(0, 0, 0, 32'h0, 1, 8'h10, 0);
    check("wait addr byte3", bus.mem_address, 32'h13);
    check("wait valid early", 32'(bus.instruction_valid), 32'h0);
    step(0, 0, 0, 32'h0, 1, 8'h00, 0);
    check("wait valid N+7", 32'(bus.instruction_valid), 32'h1);
    check("wait instruction", bus.instruction, 32'h0010_0513);

    // Hold with no consumer, then back-to-back fetch at 0x14.
    held = bus.instruction;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 32'h0, 1, 8'h77, 0);
      check("hold instruction", bus.instruction, held);
      check("hold valid", 32'(bus.instruction_valid), 32'h1);
    end
    step(0, 1, 0, 32'h14, 0, 8'h00, 1);
    check("b2b mem_read", 32'(bus.mem_read), 32'h1);
    check("b2b mem_address", bus.mem_address, 32'h14);
    check("b2b valid cleared", 32'(bus.instruction_valid), 32'h0);

    // Flush after byte 1 accepted; restart must begin at byte 0.
    step(0, 0, 0, 32'h0, 1, 8'haa, 0);
    step(0, 0, 0, 32'h0, 1, 8'hbb, 0);
    check("pre-flush addr", bus.mem_address, 32'h16);
    step(0, 1, 1, 32'h30, 1, 8'hcc, 1);
    check("flush mem_read", 32'(bus.mem_read), 32'h0);
    check("flush valid", 32'(bus.instruction_valid), 32'h0);
    check("flush busy", 32'(bus.busy), 32'h0);
    step(0, 1, 0, 32'h20, 0, 8'h00, 0);
    check("restart addr", bus.mem_address, 32'h20);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1, 8'(8'h41 + i), 0);
    check("restart instruction", bus.instruction, 32'h4443_4241);
    step(0, 0, 0, 32'h0, 0, 8'h00, 1);

    // Address wrap at the top of the space, then reset during byte 2.
    step(0, 1, 0, 32'hFFFF_FFFC, 0, 8'h00, 0);
    check("wrap addr0", bus.mem_address, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0, 1, 8'h01, 0);
    step(0, 0, 0, 32'h0, 1, 8'h02, 0);
    step(0, 0, 0, 32'h0, 1, 8'h03, 0);
    check("wrap addr3", bus.mem_address, 32'hFFFF_FFFF);
    step(0, 0, 0, 32'h0, 1, 8'h04, 1);
    check("wrap instruction", bus.instruction, 32'h0403_0201);
    step(0, 1, 0, 32'hFFFF_FFFC, 1, 8'h00, 1);
    step(0, 0, 0, 32'h0, 1, 8'h11, 0);
    step(0, 0, 0, 32'h0, 1, 8'h22, 0);
    check("pre-reset addr", bus.mem_address, 32'hFFFF_FFFE);
    step(1, 1, 0, 32'h0, 1, 8'h33, 1);
    check("reset mem_read", 32'(bus.mem_read), 32'h0);
    check("reset valid", 32'(bus.instruction_valid), 32'h0);
    check("reset instruction", bus.instruction, 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset misaligned", 32'(bus.misaligned), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      if ($urandom_range(0, 19) != 0) pc[1:0] = 2'b00;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
           pc, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
